// File: rtl/wb_sel_pipe.sv
// Writeback stage: selects register-file write data, extracts sub-word loads,
// and waits for memory with a bounded timeout while forwarding the pending load.
module wb_sel_pipe #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int MEM_TIMEOUT  = 15,
    parameter int R0_HARDWIRED = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    wsel,
    input  logic          wen,
    input  logic [AW-1:0] wreg,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] oprand2,
    input  logic [DW-1:0] jra,
    input  logic [1:0]    ld_size,
    input  logic          ld_signed,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] mem_out,
    input  logic          mem_valid,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic          err_timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT - 1);
    localparam bit R0_HW = (R0_HARDWIRED != 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ld_wen_q;
    logic [1:0]    ld_size_q;
    logic          ld_signed_q;
    logic [1:0]    ld_addr_q;

    logic          accept;
    logic          is_mem;
    logic          mem_done;
    logic          tmo;
    logic [DW-1:0] sel_data;
    logic [DW-1:0] ext_data;
    logic [7:0]    b_lane;
    logic [15:0]   h_lane;

    logic          we_d;
    logic          err_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;

    assign in_ready  = (state_q == S_IDLE);
    assign fwd_valid = (state_q == S_WAIT);
    assign accept    = in_valid & in_ready;
    assign is_mem    = (wsel == 3'd1);
    assign mem_done  = (state_q == S_WAIT) & mem_valid;
    assign tmo       = (state_q == S_WAIT) & ~mem_valid & (cnt_q == TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_mem) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_valid || cnt_q == TMAX) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        unique case (1'b1)
            wsel == 3'd0: sel_data = alu_out;
            wsel == 3'd2: sel_data = oprand2;
            wsel == 3'd3: sel_data = jra;
            default:      sel_data = '0;
        endcase
    end

    // Lanes always come from the low 32 bits regardless of DW.
    always_comb begin
        b_lane = mem_out[7:0];
        unique case (ld_addr_q)
            2'd0: b_lane = mem_out[7:0];
            2'd1: b_lane = mem_out[15:8];
            2'd2: b_lane = mem_out[23:16];
            2'd3: b_lane = mem_out[31:24];
            default: b_lane = mem_out[7:0];
        endcase
        h_lane = ld_addr_q[1] ? mem_out[31:16] : mem_out[15:0];
    end

    always_comb begin
        ext_data = mem_out;
        unique case (1'b1)
            ld_size_q == 2'd0:
                ext_data = {{(DW-8){ld_signed_q & b_lane[7]}}, b_lane};
            ld_size_q == 2'd1:
                ext_data = {{(DW-16){ld_signed_q & h_lane[15]}}, h_lane};
            default:
                ext_data = mem_out;
        endcase
    end

    always_comb begin
        we_d   = 1'b0;
        err_d  = 1'b0;
        addr_d = wreg;
        data_d = sel_data;
        if (accept && !is_mem) begin
            we_d = wen & ~(R0_HW & (wreg == '0));
        end
        if (mem_done) begin
            we_d   = ld_wen_q & ~(R0_HW & (fwd_addr == '0));
            addr_d = fwd_addr;
            data_d = ext_data;
        end
        if (tmo) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            err_timeout <= 1'b0;
            fwd_addr    <= '0;
            ld_wen_q    <= 1'b0;
            ld_size_q   <= '0;
            ld_signed_q <= 1'b0;
            ld_addr_q   <= '0;
        end else begin
            wb_we       <= we_d;
            err_timeout <= err_d;
            if (we_d) begin
                wb_addr <= addr_d;
                wb_data <= data_d;
            end
            if (accept && is_mem) begin
                fwd_addr    <= wreg;
                ld_wen_q    <= wen;
                ld_size_q   <= ld_size;
                ld_signed_q <= ld_signed;
                ld_addr_q   <= addr_lo;
            end
        end
    end

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Directed checks for wb_sel_pipe: source select, load extraction,
// wait/timeout behaviour, r0 suppression and reset during a pending load.
module tb_wb_sel_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  wsel;
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] alu_out;
    logic [31:0] oprand2;
    logic [31:0] jra;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [1:0]  addr_lo;
    logic [31:0] mem_out;
    logic        mem_valid;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic        err_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    wb_sel_pipe #(
        .DW(32), .AW(5), .MEM_TIMEOUT(15), .R0_HARDWIRED(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .wsel(wsel), .wen(wen), .wreg(wreg),
        .alu_out(alu_out), .oprand2(oprand2), .jra(jra),
        .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr_lo),
        .mem_out(mem_out), .mem_valid(mem_valid),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a load, wait dly cycles with mem_valid low, then return mo.
    task automatic load(input logic [4:0] r, input logic [1:0] sz,
                        input logic sg, input logic [1:0] alo,
                        input logic [31:0] mo, input int dly);
        in_valid  = 1'b1;
        wsel      = 3'd1;
        wen       = 1'b1;
        wreg      = r;
        ld_size   = sz;
        ld_signed = sg;
        addr_lo   = alo;
        mem_out   = 32'h5A5A_5A5A;
        mem_valid = 1'b0;
        tick();
        in_valid  = 1'b0;
        wsel      = 3'd0;
        ld_size   = ~sz;
        ld_signed = ~sg;
        addr_lo   = ~alo;
        repeat (dly) tick();
        mem_out   = mo;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; wsel = 3'd0; wen = 1'b0;
        wreg = 5'd0; alu_out = '0; oprand2 = '0; jra = '0;
        ld_size = 2'd0; ld_signed = 1'b0; addr_lo = 2'd0;
        mem_out = '0; mem_valid = 1'b0;
        tick(); tick();
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_addr", 32'(wb_addr), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_fwd", 32'(fwd_valid), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        rst = 1'b0;

        in_valid = 1'b1; wsel = 3'd0; wen = 1'b1; wreg = 5'd3;
        alu_out = 32'h1234_5678;
        tick();
        chk("alu_we", 32'(wb_we), 32'd1);
        chk("alu_addr", 32'(wb_addr), 32'd3);
        chk("alu_data", wb_data, 32'h1234_5678);
        chk("alu_rdy", 32'(in_ready), 32'd1);

        wsel = 3'd3; jra = 32'h100; wreg = 5'd31;
        tick();
        chk("jra_we", 32'(wb_we), 32'd1);
        chk("jra_addr", 32'(wb_addr), 32'd31);
        chk("jra_data", wb_data, 32'h100);
        wsel = 3'd2; oprand2 = 32'hFFFF_0000; wreg = 5'd4;
        tick();
        chk("opr_we", 32'(wb_we), 32'd1);
        chk("opr_data", wb_data, 32'hFFFF_0000);
        wsel = 3'd5; wreg = 5'd5;
        tick();
        chk("zero_we", 32'(wb_we), 32'd1);
        chk("zero_addr", 32'(wb_addr), 32'd5);
        chk("zero_data", wb_data, 32'd0);

        in_valid = 1'b0; wsel = 3'd0; alu_out = 32'hAAAA_AAAA;
        tick();
        chk("idle_we", 32'(wb_we), 32'd0);
        chk("idle_hold", wb_data, 32'd0);

        in_valid = 1'b1; wreg = 5'd0; alu_out = 32'hDEAD_BEEF;
        tick();
        chk("r0_we", 32'(wb_we), 32'd0);
        chk("r0_hold", 32'(wb_addr), 32'd5);
        wen = 1'b0; wreg = 5'd7;
        tick();
        chk("wen0_we", 32'(wb_we), 32'd0);
        wen = 1'b1; in_valid = 1'b0;

        // Signed byte; mem_valid high during acceptance must be ignored.
        in_valid = 1'b1; wsel = 3'd1; wreg = 5'd9; ld_size = 2'd0;
        ld_signed = 1'b1; addr_lo = 2'd2; mem_out = 32'h1111_1111;
        mem_valid = 1'b1;
        tick();
        in_valid = 1'b0; wsel = 3'd0; mem_valid = 1'b0;
        ld_size = 2'd2; ld_signed = 1'b0; addr_lo = 2'd0;
        for (int i = 0; i < 3; i++) begin
            chk("sb_rdy", 32'(in_ready), 32'd0);
            chk("sb_fwd", 32'(fwd_valid), 32'd1);
            chk("sb_we", 32'(wb_we), 32'd0);
            if (i < 2) tick();
        end
        chk("sb_faddr", 32'(fwd_addr), 32'd9);
        mem_out = 32'h0080_0000; mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("sb_we1", 32'(wb_we), 32'd1);
        chk("sb_addr", 32'(wb_addr), 32'd9);
        chk("sb_data", wb_data, 32'hFFFF_FF80);
        chk("sb_fwd0", 32'(fwd_valid), 32'd0);
        chk("sb_rdy1", 32'(in_ready), 32'd1);

        load(5'd9, 2'd0, 1'b0, 2'd2, 32'h0080_0000, 0);
        chk("ub_data", wb_data, 32'h0000_0080);
        load(5'd10, 2'd1, 1'b0, 2'd3, 32'h8001_7FFF, 1);
        chk("uh_data", wb_data, 32'h0000_8001);
        chk("uh_addr", 32'(wb_addr), 32'd10);
        load(5'd11, 2'd1, 1'b1, 2'd1, 32'h1234_8000, 0);
        chk("sh_data", wb_data, 32'hFFFF_8000);
        load(5'd11, 2'd0, 1'b0, 2'd3, 32'hAB00_0000, 0);
        chk("ub3_data", wb_data, 32'h0000_00AB);
        load(5'd12, 2'd3, 1'b1, 2'd1, 32'hCAFE_BABE, 2);
        chk("w_data", wb_data, 32'hCAFE_BABE);
        tick();
        chk("w_pulse", 32'(wb_we), 32'd0);

        in_valid = 1'b1; wsel = 3'd1; wreg = 5'd12;
        tick();
        in_valid = 1'b0; wsel = 3'd0;
        repeat (14) tick();
        chk("to_err0", 32'(err_timeout), 32'd0);
        chk("to_rdy0", 32'(in_ready), 32'd0);
        tick();
        chk("to_err1", 32'(err_timeout), 32'd1);
        chk("to_we", 32'(wb_we), 32'd0);
        chk("to_fwd", 32'(fwd_valid), 32'd0);
        chk("to_rdy1", 32'(in_ready), 32'd1);
        tick();
        chk("to_pulse", 32'(err_timeout), 32'd0);

        load(5'd13, 2'd2, 1'b0, 2'd0, 32'h600D_F00D, 14);
        chk("last_we", 32'(wb_we), 32'd1);
        chk("last_data", wb_data, 32'h600D_F00D);
        chk("last_err", 32'(err_timeout), 32'd0);

        in_valid = 1'b1; wsel = 3'd1; wen = 1'b0; wreg = 5'd20;
        tick();
        in_valid = 1'b0; wsel = 3'd0; wen = 1'b1;
        chk("nw_rdy", 32'(in_ready), 32'd0);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("nw_we", 32'(wb_we), 32'd0);
        chk("nw_rdy1", 32'(in_ready), 32'd1);

        in_valid = 1'b1; wsel = 3'd1; wreg = 5'd14;
        tick();
        in_valid = 1'b0; wsel = 3'd0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_we", 32'(wb_we), 32'd0);
        chk("mr_addr", 32'(wb_addr), 32'd0);
        chk("mr_data", wb_data, 32'd0);
        chk("mr_fwd", 32'(fwd_valid), 32'd0);
        chk("mr_faddr", 32'(fwd_addr), 32'd0);
        chk("mr_err", 32'(err_timeout), 32'd0);
        chk("mr_rdy", 32'(in_ready), 32'd1);
        mem_out = 32'h7777_7777; mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("mr_late_we", 32'(wb_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
